// File: rtl/noc_output_vc_switch_pkg.sv
// Shared parameters, flit type and grant-decode helpers for the output VC switch.
// Grants are one-hot over the five router input ports.
package noc_output_vc_switch_pkg;

  localparam int Noc_VC_Channel = 2;
  localparam int Noc_Flit_Width = 32;
  localparam int Noc_VC_Depth   = 4;
  localparam int NOC_PORTS      = 5;

  typedef struct packed {
    logic                      tail;
    logic [Noc_Flit_Width-1:0] data;
  } noc_flit_t;

  function automatic logic grant_onehot(input logic [NOC_PORTS-1:0] g);
    return $onehot(g);
  endfunction

  function automatic logic [2:0] grant_port(input logic [NOC_PORTS-1:0] g);
    grant_port = 3'd0;
    for (int p = 0; p < NOC_PORTS; p++) begin
      if (g[p]) grant_port = 3'(p);
    end
  endfunction

endpackage

// File: rtl/noc_output_vc_switch_if.sv
// Grant, input-side flit/pop, output link and credit signals of the output VC switch.
// master = environment/port controller side, slave = the switch.
interface noc_output_vc_switch_if #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32
);
  localparam int VCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0][4:0]                 grant_i;
  logic [CHANNELS-1:0]                      free_o;
  logic [4:0][CHANNELS-1:0]                 in_valid;
  logic [4:0][CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [4:0][CHANNELS-1:0]                 in_tail;
  logic [4:0][CHANNELS-1:0]                 in_ready;
  logic                                     out_valid;
  logic [VCW-1:0]                           out_vc;
  logic [FLIT_WIDTH-1:0]                    out_flit;
  logic                                     out_tail;
  logic [CHANNELS-1:0]                      credit_i;
  logic                                     error_o;

  modport master (
    output grant_i, in_valid, in_flit, in_tail, credit_i,
    input  free_o, in_ready, out_valid, out_vc, out_flit, out_tail, error_o
  );

  modport slave (
    input  grant_i, in_valid, in_flit, in_tail, credit_i,
    output free_o, in_ready, out_valid, out_vc, out_flit, out_tail, error_o
  );

endinterface

// File: rtl/noc_output_vc_switch_credit.sv
// Per-VC downstream credit counter: starts full, one credit per flit sent.
// Returns while full saturate and raise a one-cycle overflow flag.
module noc_vc_credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic consume_i,
  input  logic credit_i,
  output logic avail_o,
  output logic ovf_o
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    case ({consume_i, credit_i})
      2'b10:   cnt_d = cnt_q - CW'(1);
      2'b01: begin
        if (cnt_q == CW'(CREDITS)) ovf_o = 1'b1;
        else                       cnt_d = cnt_q + CW'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= CW'(CREDITS);
    else       cnt_q <= cnt_d;
  end

  assign avail_o = (cnt_q != '0);

endmodule

// File: rtl/noc_output_vc_switch.sv
// Output VC switch: per-flit round-robin over granted VCs onto one link, 1-cycle registered output.
// No output backpressure; VCs stall only on zero credits or the post-tail grant-pop lock.
module noc_output_vc_switch
  import noc_output_vc_switch_pkg::*;
#(
  parameter int CHANNELS   = Noc_VC_Channel,
  parameter int FLIT_WIDTH = Noc_Flit_Width,
  parameter int CREDITS    = Noc_VC_Depth
) (
  input  logic                   noc_clk,
  input  logic                   noc_rst,
  noc_output_vc_switch_if.slave  bus
);
  localparam int VCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       granted, multi, has_valid, avail, eligible, send, ovf;
  logic [CHANNELS-1:0][2:0]  src_port;
  logic [CHANNELS-1:0]       lock_q;
  logic [VCW-1:0]            ptr_q, ptr_d, win_vc;
  logic                      win_any, win_tail;
  logic [FLIT_WIDTH-1:0]     win_flit;
  logic [4:0][CHANNELS-1:0]  ready;

  logic                      out_valid_q, out_tail_q, error_q;
  logic [VCW-1:0]            out_vc_q;
  logic [FLIT_WIDTH-1:0]     out_flit_q;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      granted[c]   = grant_onehot(bus.grant_i[c]);
      multi[c]     = (|bus.grant_i[c]) && !granted[c];
      src_port[c]  = grant_port(bus.grant_i[c]);
      has_valid[c] = bus.in_valid[src_port[c]][c];
    end
    eligible = granted & has_valid & avail & ~lock_q;
  end

  // First eligible VC at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    win_any = 1'b0;
    win_vc  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!win_any && eligible[idx]) begin
        win_any = 1'b1;
        win_vc  = VCW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (win_any) ptr_d = (win_vc == VCW'(CHANNELS - 1)) ? '0 : win_vc + VCW'(1);
  end

  assign win_flit = bus.in_flit[src_port[win_vc]][win_vc];
  assign win_tail = bus.in_tail[src_port[win_vc]][win_vc];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      send[c] = win_any && (win_vc == VCW'(c));
    end
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ready[p][c] = send[c] && (src_port[c] == 3'(p));
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_credit
    noc_vc_credit_counter #(.CREDITS(CREDITS)) u_credit (
      .clk_i     (noc_clk),
      .rst_i     (noc_rst),
      .consume_i (send[c]),
      .credit_i  (bus.credit_i[c]),
      .avail_o   (avail[c]),
      .ovf_o     (ovf[c])
    );
  end

  // The lock spans exactly the cycle the grant FIFO pops, so it doubles as the free pulse.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      out_flit_q  <= '0;
      out_tail_q  <= 1'b0;
      lock_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= win_any;
      out_tail_q  <= win_any && win_tail;
      if (win_any) begin
        out_vc_q   <= win_vc;
        out_flit_q <= win_flit;
      end
      lock_q      <= send & {CHANNELS{win_tail}};
      error_q     <= error_q | (|multi) | (|ovf);
    end
  end

  assign bus.in_ready  = ready;
  assign bus.free_o    = lock_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vc    = out_vc_q;
  assign bus.out_flit  = out_flit_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.error_o   = error_q;

endmodule
